// File: rtl/ptr_mem_port_pkg.sv
// Shared types for the pointer load/store sequencer: FSM states, post-modify
// codes and the post-modify hazard rule.
package ptr_mem_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WB     = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    POST_NONE  = 2'b00,
    POST_INC   = 2'b01,
    POST_DEC   = 2'b10,
    POST_NONE2 = 2'b11
  } post_e;

  // A load into either half of the pair being modified wins over the post-modify.
  function automatic logic post_allowed(logic store, logic [3:0] dest, logic [3:0] ptr_sel);
    post_allowed = !ptr_sel[0] && (store || (dest[3:1] != ptr_sel[3:1]));
  endfunction

endpackage

// File: rtl/ptr_mem_port_if.sv
// Bundle of request, data-memory and register-file signals around the
// pointer load/store sequencer.
interface ptr_mem_port_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_post;
  logic [3:0]  req_dest;
  logic [3:0]  req_ptr_sel;
  logic [7:0]  ptr_lo;
  logic [7:0]  ptr_hi;
  logic [7:0]  req_wdata;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  logic        rf_write_en;
  logic [3:0]  rf_wsel;
  logic [7:0]  rf_wdata;
  logic        rf_inc;
  logic        rf_dec;
  logic [3:0]  rf_ptr_sel;
  logic        err;

  modport slave (
    input  req_valid, req_store, req_post, req_dest, req_ptr_sel, ptr_lo, ptr_hi, req_wdata,
    input  mem_rdata, mem_ack,
    output req_ready, mem_addr, mem_wdata, mem_re, mem_we,
    output rf_write_en, rf_wsel, rf_wdata, rf_inc, rf_dec, rf_ptr_sel, err
  );

  modport master (
    output req_valid, req_store, req_post, req_dest, req_ptr_sel, ptr_lo, ptr_hi, req_wdata,
    output mem_rdata, mem_ack,
    input  req_ready, mem_addr, mem_wdata, mem_re, mem_we,
    input  rf_write_en, rf_wsel, rf_wdata, rf_inc, rf_dec, rf_ptr_sel, err
  );

endinterface

// File: rtl/ptr_mem_port.sv
// Pointer-pair load/store sequencer: one handshaked byte access to data memory,
// then a single write-back cycle driving the regfile write and inc/dec ports.
module ptr_mem_port
  import ptr_mem_port_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input logic           clk,
  input logic           rst_n,
  ptr_mem_port_if.slave bus
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [3:0]  dest_q;
  logic [3:0]  ptr_sel_q;
  post_e       post_q;
  logic        store_q;
  logic [7:0]  rdata_q;
  logic        abort_q;
  logic [7:0]  cnt_q;

  logic accept;
  logic timeout_hit;

  assign accept      = (state_q == ST_IDLE) && bus.req_valid;
  assign timeout_hit = (state_q == ST_ACCESS) && !bus.mem_ack && (cnt_q == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.req_valid) state_d = ST_ACCESS;
      ST_ACCESS: if (bus.mem_ack || timeout_hit) state_d = ST_WB;
      ST_WB:     state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request fields are captured once at accept; the counter only runs while waiting for ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      dest_q    <= '0;
      ptr_sel_q <= '0;
      post_q    <= POST_NONE;
      store_q   <= 1'b0;
      rdata_q   <= '0;
      abort_q   <= 1'b0;
      cnt_q     <= '0;
    end else if (accept) begin
      addr_q    <= {bus.ptr_hi, bus.ptr_lo};
      wdata_q   <= bus.req_wdata;
      dest_q    <= bus.req_dest;
      ptr_sel_q <= bus.req_ptr_sel;
      post_q    <= post_e'(bus.req_post);
      store_q   <= bus.req_store;
      abort_q   <= 1'b0;
      cnt_q     <= '0;
    end else if (state_q == ST_ACCESS) begin
      if (bus.mem_ack)      rdata_q <= bus.mem_rdata;
      else if (timeout_hit) abort_q <= 1'b1;
      else                  cnt_q   <= cnt_q + 8'd1;
    end
  end

  always_comb begin
    bus.req_ready   = (state_q == ST_IDLE);
    bus.mem_addr    = addr_q;
    bus.mem_wdata   = wdata_q;
    bus.mem_re      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.rf_write_en = 1'b0;
    bus.rf_wsel     = '0;
    bus.rf_wdata    = '0;
    bus.rf_inc      = 1'b0;
    bus.rf_dec      = 1'b0;
    bus.rf_ptr_sel  = '0;
    bus.err         = 1'b0;
    if (state_q == ST_ACCESS) begin
      bus.mem_re = !store_q;
      bus.mem_we = store_q;
    end else if (state_q == ST_WB) begin
      if (abort_q) begin
        bus.err = 1'b1;
      end else begin
        if (!store_q) begin
          bus.rf_write_en = 1'b1;
          bus.rf_wsel     = dest_q;
          bus.rf_wdata    = rdata_q;
        end
        if (post_allowed(store_q, dest_q, ptr_sel_q) &&
            (post_q == POST_INC || post_q == POST_DEC)) begin
          bus.rf_inc     = (post_q == POST_INC);
          bus.rf_dec     = (post_q == POST_DEC);
          bus.rf_ptr_sel = ptr_sel_q;
        end
      end
    end
  end

endmodule
